// File: rtl/ps2_kbd_pkg.sv
// rtl/ps2_kbd_pkg.sv - shared scan codes, ASCII constants and FSM state type for the PS/2 decoder
package ps2_kbd_pkg;

  // Prefix bytes
  localparam logic [7:0] SC_BRK      = 8'hF0;
  localparam logic [7:0] SC_EXT      = 8'hE0;

  // Modifier and special make codes
  localparam logic [7:0] SC_LSHIFT   = 8'h12;
  localparam logic [7:0] SC_RSHIFT   = 8'h59;
  localparam logic [7:0] SC_CAPS     = 8'h58;
  localparam logic [7:0] SC_CTRL     = 8'h14;
  localparam logic [7:0] SC_ENTER    = 8'h5A;
  localparam logic [7:0] SC_KP_SLASH = 8'h4A;

  // ASCII constants
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_TAB   = 8'h09;
  localparam logic [7:0] ASCII_STAR  = 8'h2A;
  localparam logic [7:0] ASCII_SLASH = 8'h2F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } kbd_state_t;

  // True for 'A'..'Z' and 'a'..'z'; the LUT only produces these for letter keys
  function automatic logic is_letter(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
  endfunction

endpackage

// File: rtl/scan_lut.sv
// rtl/scan_lut.sv - combinational Set-2 make code to ASCII table (letters, digits, punctuation)
module scan_lut
  import ps2_kbd_pkg::*;
(
  input  logic       upper,
  input  logic       shift,
  input  logic [7:0] scan_code,
  output logic [7:0] ascii,
  output logic       mapped
);

  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_LET  = 2'd1;
  localparam logic [1:0] K_PAIR = 2'd2;
  localparam logic [1:0] K_FIX  = 2'd3;

  logic [1:0] kind;
  logic [7:0] base;
  logic [7:0] alt;

  // Look up base glyph, shifted glyph and key class, then pick the glyph for the modifiers
  always_comb begin
    kind = K_NONE;
    base = 8'h00;
    alt  = 8'h00;
    case (scan_code)
      8'h1C: {kind, base} = {K_LET, 8'h61};   8'h32: {kind, base} = {K_LET, 8'h62};
      8'h21: {kind, base} = {K_LET, 8'h63};   8'h23: {kind, base} = {K_LET, 8'h64};
      8'h24: {kind, base} = {K_LET, 8'h65};   8'h2B: {kind, base} = {K_LET, 8'h66};
      8'h34: {kind, base} = {K_LET, 8'h67};   8'h33: {kind, base} = {K_LET, 8'h68};
      8'h43: {kind, base} = {K_LET, 8'h69};   8'h3B: {kind, base} = {K_LET, 8'h6A};
      8'h42: {kind, base} = {K_LET, 8'h6B};   8'h4B: {kind, base} = {K_LET, 8'h6C};
      8'h3A: {kind, base} = {K_LET, 8'h6D};   8'h31: {kind, base} = {K_LET, 8'h6E};
      8'h44: {kind, base} = {K_LET, 8'h6F};   8'h4D: {kind, base} = {K_LET, 8'h70};
      8'h15: {kind, base} = {K_LET, 8'h71};   8'h2D: {kind, base} = {K_LET, 8'h72};
      8'h1B: {kind, base} = {K_LET, 8'h73};   8'h2C: {kind, base} = {K_LET, 8'h74};
      8'h3C: {kind, base} = {K_LET, 8'h75};   8'h2A: {kind, base} = {K_LET, 8'h76};
      8'h1D: {kind, base} = {K_LET, 8'h77};   8'h22: {kind, base} = {K_LET, 8'h78};
      8'h35: {kind, base} = {K_LET, 8'h79};   8'h1A: {kind, base} = {K_LET, 8'h7A};
      8'h16: {kind, base, alt} = {K_PAIR, 8'h31, 8'h21};
      8'h1E: {kind, base, alt} = {K_PAIR, 8'h32, 8'h40};
      8'h26: {kind, base, alt} = {K_PAIR, 8'h33, 8'h23};
      8'h25: {kind, base, alt} = {K_PAIR, 8'h34, 8'h24};
      8'h2E: {kind, base, alt} = {K_PAIR, 8'h35, 8'h25};
      8'h36: {kind, base, alt} = {K_PAIR, 8'h36, 8'h5E};
      8'h3D: {kind, base, alt} = {K_PAIR, 8'h37, 8'h26};
      8'h3E: {kind, base, alt} = {K_PAIR, 8'h38, 8'h2A};
      8'h46: {kind, base, alt} = {K_PAIR, 8'h39, 8'h28};
      8'h45: {kind, base, alt} = {K_PAIR, 8'h30, 8'h29};
      8'h0E: {kind, base, alt} = {K_PAIR, 8'h60, 8'h7E};
      8'h4E: {kind, base, alt} = {K_PAIR, 8'h2D, 8'h5F};
      8'h55: {kind, base, alt} = {K_PAIR, 8'h3D, 8'h2B};
      8'h54: {kind, base, alt} = {K_PAIR, 8'h5B, 8'h7B};
      8'h5B: {kind, base, alt} = {K_PAIR, 8'h5D, 8'h7D};
      8'h5D: {kind, base, alt} = {K_PAIR, 8'h5C, 8'h7C};
      8'h4C: {kind, base, alt} = {K_PAIR, 8'h3B, 8'h3A};
      8'h52: {kind, base, alt} = {K_PAIR, 8'h27, 8'h22};
      8'h41: {kind, base, alt} = {K_PAIR, 8'h2C, 8'h3C};
      8'h49: {kind, base, alt} = {K_PAIR, 8'h2E, 8'h3E};
      8'h4A: {kind, base, alt} = {K_PAIR, 8'h2F, 8'h3F};
      8'h29: {kind, base} = {K_FIX, 8'h20};
      8'h5A: {kind, base} = {K_FIX, ASCII_CR};
      8'h66: {kind, base} = {K_FIX, ASCII_BS};
      8'h0D: {kind, base} = {K_FIX, ASCII_TAB};
      default: ;
    endcase
  end

  // Letters follow upper (shift XOR caps), punctuation follows shift only
  always_comb begin
    mapped = (kind != K_NONE);
    case (kind)
      K_LET:   ascii = upper ? (base - 8'h20) : base;
      K_PAIR:  ascii = shift ? alt : base;
      default: ascii = base;
    endcase
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 Set-2 decoder with prefix FSM, modifiers and output FIFO; KEY_CTRL_EN adds Ctrl
module ps2_key_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int EMIT_UNMAPPED = 0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic [7:0] ascii_code,
  output logic       ascii_valid,
  input  logic       ascii_ready,
  output logic       shift_held,
  output logic       caps_lock,
  output logic       overflow,
  input  logic       ovf_clr
);

  localparam int AW = $clog2(DEPTH);

  kbd_state_t state;
  logic       lshift, rshift;
  logic [7:0] lut_ascii;
  logic       lut_mapped;
  logic       push;
  logic [7:0] push_data;
  logic       is_prefix;
  logic       is_modifier;

  assign shift_held = lshift | rshift;
  assign is_prefix  = (scan_code == SC_BRK) || (scan_code == SC_EXT);

`ifdef KEY_CTRL_EN
  logic lctrl, rctrl;
  assign is_modifier = (scan_code == SC_LSHIFT) || (scan_code == SC_RSHIFT) ||
                       (scan_code == SC_CAPS)   || (scan_code == SC_CTRL);
`else
  assign is_modifier = (scan_code == SC_LSHIFT) || (scan_code == SC_RSHIFT) ||
                       (scan_code == SC_CAPS);
`endif

  scan_lut u_lut (
    .upper     (shift_held ^ caps_lock),
    .shift     (shift_held),
    .scan_code (scan_code),
    .ascii     (lut_ascii),
    .mapped    (lut_mapped)
  );

  // Decide whether the current byte produces a character; it is written at this same edge
  always_comb begin
    push      = 1'b0;
    push_data = 8'h00;
    if (scan_valid) begin
      case (state)
        ST_IDLE: begin
          if (!is_prefix && !is_modifier) begin
            if (lut_mapped) begin
              push      = 1'b1;
              push_data = lut_ascii;
`ifdef KEY_CTRL_EN
              if ((lctrl | rctrl) && is_letter(lut_ascii))
                push_data = lut_ascii & 8'h1F;
`endif
            end else if (EMIT_UNMAPPED != 0) begin
              push      = 1'b1;
              push_data = ASCII_STAR;
            end
          end
        end
        ST_EXT: begin
          if (scan_code == SC_ENTER) begin
            push      = 1'b1;
            push_data = ASCII_CR;
          end else if (scan_code == SC_KP_SLASH) begin
            push      = 1'b1;
            push_data = ASCII_SLASH;
          end
        end
        default: ;
      endcase
    end
  end

  // Prefix FSM and modifier state; a stray prefix outside IDLE drops back to IDLE
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      caps_lock <= 1'b0;
`ifdef KEY_CTRL_EN
      lctrl     <= 1'b0;
      rctrl     <= 1'b0;
`endif
    end else if (scan_valid) begin
      case (state)
        ST_IDLE: begin
          if (scan_code == SC_BRK)      state <= ST_BRK;
          else if (scan_code == SC_EXT) state <= ST_EXT;
          else if (scan_code == SC_LSHIFT) lshift <= 1'b1;
          else if (scan_code == SC_RSHIFT) rshift <= 1'b1;
          else if (scan_code == SC_CAPS)   caps_lock <= ~caps_lock;
`ifdef KEY_CTRL_EN
          else if (scan_code == SC_CTRL)   lctrl <= 1'b1;
`endif
        end
        ST_BRK: begin
          state <= ST_IDLE;
          if (scan_code == SC_LSHIFT) lshift <= 1'b0;
          if (scan_code == SC_RSHIFT) rshift <= 1'b0;
`ifdef KEY_CTRL_EN
          if (scan_code == SC_CTRL)   lctrl  <= 1'b0;
`endif
        end
        ST_EXT: begin
          state <= (scan_code == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
`ifdef KEY_CTRL_EN
          if (scan_code == SC_CTRL) rctrl <= 1'b1;
`endif
        end
        default: begin
          state <= ST_IDLE;
`ifdef KEY_CTRL_EN
          if (scan_code == SC_CTRL) rctrl <= 1'b0;
`endif
        end
      endcase
    end
  end

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, rd_next;
  logic        full, pop, do_push;

  assign ascii_valid = (wr_ptr != rd_ptr);
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop         = ascii_valid & ascii_ready;
  assign do_push     = push & (~full | pop);
  assign rd_next     = rd_ptr + {{AW{1'b0}}, pop};

  // FIFO storage; no reset needed since the pointers qualify every entry
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Pointers, registered head and sticky overflow (set wins over clear)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ascii_code <= 8'h00;
      overflow   <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + {{AW{1'b0}}, do_push};
      rd_ptr <= rd_next;
      if (do_push && (rd_next == wr_ptr))
        ascii_code <= push_data;
      else if (rd_next != wr_ptr)
        ascii_code <= mem[rd_next[AW-1:0]];
      if (push && full && !pop)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - directed self-checking bench for ps2_key_decoder
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic [7:0] scan_code = 8'h00;
  logic       scan_valid = 1'b0;
  logic [7:0] ascii_code;
  logic       ascii_valid;
  logic       ascii_ready = 1'b0;
  logic       shift_held;
  logic       caps_lock;
  logic       overflow;
  logic       ovf_clr = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  ps2_key_decoder #(.DEPTH(8), .EMIT_UNMAPPED(0)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .scan_code   (scan_code),
    .scan_valid  (scan_valid),
    .ascii_code  (ascii_code),
    .ascii_valid (ascii_valid),
    .ascii_ready (ascii_ready),
    .shift_held  (shift_held),
    .caps_lock   (caps_lock),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    scan_code  = b;
    scan_valid = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
  endtask

  // Waits (bounded) for a head character, captures it and pops it
  task automatic pop_char(output logic [7:0] c, output logic got);
    got = 1'b0;
    c   = 8'h00;
    for (int i = 0; i < 20 && !got; i++) begin
      if (ascii_valid) got = 1'b1;
      else @(negedge clk);
    end
    if (got) begin
      c = ascii_code;
      ascii_ready = 1'b1;
      @(negedge clk);
      ascii_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    #2 resetn = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (ascii_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", ascii_valid); end
    n_cmp++; if (ascii_code !== 8'h00) begin n_bad++; $display("FAIL reset_code got %h exp 00", ascii_code); end
    n_cmp++; if (shift_held !== 1'b0) begin n_bad++; $display("FAIL reset_shift got %b exp 0", shift_held); end
    n_cmp++; if (caps_lock !== 1'b0) begin n_bad++; $display("FAIL reset_caps got %b exp 0", caps_lock); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] c; logic got;
    send(8'h1C);
    n_cmp++; if (ascii_valid !== 1'b1) begin n_bad++; $display("FAIL basic_latency valid got %b exp 1", ascii_valid); end
    n_cmp++; if (ascii_code !== 8'h61) begin n_bad++; $display("FAIL basic_code got %h exp 61", ascii_code); end
    send(8'hF0); send(8'h1C);
    pop_char(c, got);
    n_cmp++; if (got !== 1'b1 || c !== 8'h61) begin n_bad++; $display("FAIL basic_pop got %h (valid %b) exp 61", c, got); end
    n_cmp++; if (ascii_valid !== 1'b0) begin n_bad++; $display("FAIL basic_single valid got %b exp 0", ascii_valid); end
  endtask

  task automatic test_shift();
    logic [7:0] c; logic got;
    logic [7:0] exp_q [3];
    exp_q = '{8'h41, 8'h21, 8'h61};
    send(8'h12);
    n_cmp++; if (shift_held !== 1'b1) begin n_bad++; $display("FAIL shift_held_on got %b exp 1", shift_held); end
    send(8'h1C); send(8'h16); send(8'hF0); send(8'h12);
    n_cmp++; if (shift_held !== 1'b0) begin n_bad++; $display("FAIL shift_held_off got %b exp 0", shift_held); end
    send(8'h1C);
    for (int i = 0; i < 3; i++) begin
      pop_char(c, got);
      n_cmp++; if (got !== 1'b1 || c !== exp_q[i]) begin n_bad++; $display("FAIL shift_out%0d got %h exp %h", i, c, exp_q[i]); end
    end
  endtask

  task automatic test_caps();
    logic [7:0] c; logic got;
    logic [7:0] exp_q [3];
    exp_q = '{8'h41, 8'h31, 8'h61};
    send(8'h58); send(8'hF0); send(8'h58);
    send(8'h1C); send(8'h16); send(8'h12); send(8'h1C);
    n_cmp++; if (caps_lock !== 1'b1) begin n_bad++; $display("FAIL caps_on got %b exp 1", caps_lock); end
    for (int i = 0; i < 3; i++) begin
      pop_char(c, got);
      n_cmp++; if (got !== 1'b1 || c !== exp_q[i]) begin n_bad++; $display("FAIL caps_out%0d got %h exp %h", i, c, exp_q[i]); end
    end
    send(8'hF0); send(8'h12); send(8'h58);
    n_cmp++; if (caps_lock !== 1'b0 || shift_held !== 1'b0) begin n_bad++; $display("FAIL caps_restore got caps %b shift %b exp 0 0", caps_lock, shift_held); end
  endtask

  task automatic test_extended();
    logic [7:0] c; logic got;
    send(8'hE0); send(8'h5A);
    send(8'hE0); send(8'hF0); send(8'h5A);
    send(8'hE0); send(8'h75);
    send(8'h1C);
    pop_char(c, got);
    n_cmp++; if (got !== 1'b1 || c !== 8'h0D) begin n_bad++; $display("FAIL ext_enter got %h exp 0d", c); end
    pop_char(c, got);
    n_cmp++; if (got !== 1'b1 || c !== 8'h61) begin n_bad++; $display("FAIL ext_idle_after got %h exp 61", c); end
    n_cmp++; if (ascii_valid !== 1'b0) begin n_bad++; $display("FAIL ext_extra valid got %b exp 0", ascii_valid); end
  endtask

  task automatic test_overflow_and_full();
    logic [7:0] c; logic got;
    logic [7:0] codes [9];
    logic [7:0] exp_q [8];
    codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
    exp_q = '{8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h6A};
    for (int i = 0; i < 8; i++) send(codes[i]);
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_at_full got %b exp 0", overflow); end
    send(codes[8]);
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set got %b exp 1", overflow); end
    @(negedge clk);
    scan_code = 8'h3B; scan_valid = 1'b1; ovf_clr = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0; ovf_clr = 1'b0;
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set_beats_clr got %b exp 1", overflow); end
    repeat (3) @(negedge clk);
    n_cmp++; if (ascii_code !== 8'h61) begin n_bad++; $display("FAIL head_stable got %h exp 61", ascii_code); end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear got %b exp 0", overflow); end
    scan_code = 8'h3B; scan_valid = 1'b1; ascii_ready = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0; ascii_ready = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL full_push_pop ovf got %b exp 0", overflow); end
    for (int i = 0; i < 8; i++) begin
      pop_char(c, got);
      n_cmp++; if (got !== 1'b1 || c !== exp_q[i]) begin n_bad++; $display("FAIL drain%0d got %h exp %h", i, c, exp_q[i]); end
    end
    n_cmp++; if (ascii_valid !== 1'b0) begin n_bad++; $display("FAIL drain_empty valid got %b exp 0", ascii_valid); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] c; logic got;
    send(8'h1C);
    send(8'hF0);
    resetn = 1'b0;
    @(negedge clk);
    n_cmp++; if (ascii_valid !== 1'b0 || ascii_code !== 8'h00) begin n_bad++; $display("FAIL midreset got valid %b code %h exp 0 00", ascii_valid, ascii_code); end
    resetn = 1'b1;
    send(8'h1C);
    pop_char(c, got);
    n_cmp++; if (got !== 1'b1 || c !== 8'h61) begin n_bad++; $display("FAIL midreset_next got %h exp 61", c); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_shift();
    test_caps();
    test_extended();
    test_overflow_and_full();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
